// File: rtl/bcd_scan_display_if.sv
// Control strobes and display/count outputs of bcd_scan_display, grouped as one bus.
// The master side drives the strobes and the slave side (the display block) drives the outputs.
interface bcd_scan_display_if;
    logic        tick_scan;
    logic        tick_count;
    logic        run;
    logic        clear;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] count_bcd;
    logic        wrap;

    modport master (
        output tick_scan, tick_count, run, clear,
        input  an, seg, dp, count_bcd, wrap
    );

    modport slave (
        input  tick_scan, tick_count, run, clear,
        output an, seg, dp, count_bcd, wrap
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Four-digit BCD counter driving a multiplexed seven-segment display with inter-digit blanking.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module bcd_scan_display #(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned DP_DIGIT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd_scan_display_if.slave bus
);
    typedef enum logic {BLANK, SHOW} state_t;

    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);
    localparam logic [1:0] DP_IDX     = 2'(DP_DIGIT);
    localparam bit         DP_EN      = (DP_DIGIT < 4);

    // Active-low {g,f,e,d,c,b,a}; codes 10-15 cannot occur and decode to all-off.
    function automatic logic [6:0] decode(input logic [3:0] digit);
        case (digit)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    logic [15:0] count_q, count_d;
    logic        wrap_q, wrap_d;
    logic        carry;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.tick_count && bus.run) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        count_d[4*i +: 4] = 4'd0;
                    end else begin
                        count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    // Outputs are computed from the next state so the registers line up with the FSM;
    // seg_q doubles as the display latch, loaded only on entry to SHOW.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        case (state_q)
            BLANK: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d       = SHOW;
                    idx_d         = idx_q + 2'd1;
                    cnt_d         = BLANK_LOAD;
                    an_d          = 4'b1111;
                    an_d[idx_d]   = 1'b0;
                    seg_d         = decode(count_q[{idx_d, 2'b00} +: 4]);
                    dp_d          = ~(DP_EN && (idx_d == DP_IDX));
`ifdef LEADING_ZERO_BLANK_EN
                    if ((idx_d == 2'd1 && count_q[15:4]  == 12'd0) ||
                        (idx_d == 2'd2 && count_q[15:8]  == 8'd0)  ||
                        (idx_d == 2'd3 && count_q[15:12] == 4'd0)) begin
                        seg_d = 7'b1111111;
                        dp_d  = 1'b1;
                    end
`endif
                end
            end
            SHOW: begin
                if (bus.tick_scan) begin
                    state_d = BLANK;
                    cnt_d   = BLANK_LOAD;
                    an_d    = 4'b1111;
                    seg_d   = 7'b1111111;
                    dp_d    = 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            state_q <= BLANK;
            idx_q   <= 2'd3;
            cnt_q   <= BLANK_LOAD;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with BLANK_CYCLES=4: counter, wrap, clear priority,
// scan sequence with blanking, decimal point, display latching and asynchronous reset.
module tb_bcd_scan_display;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   wrap_seen = 1'b0;

    bcd_scan_display_if bus ();

    bcd_scan_display #(.BLANK_CYCLES(4), .DP_DIGIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD_SEG = 7'b1111111;
    localparam logic       DP2_EXP  = 1'b1;
`else
    localparam logic [6:0] LEAD_SEG = 7'b1000000;
    localparam logic       DP2_EXP  = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic count_pulse();
        bus.tick_count = 1'b1;
        @(negedge clk);
        bus.tick_count = 1'b0;
        if (bus.wrap) wrap_seen = 1'b1;
    endtask

    task automatic release_and_first_show(input string tag);
        int blanks;
        blanks = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        while (bus.an == 4'b1111 && blanks < 12) begin
            blanks++;
            @(negedge clk);
        end
        check({tag, "_blank_len"}, blanks, 3);
        check({tag, "_an"}, bus.an, 4'b1110);
        check({tag, "_seg"}, bus.seg, 7'b1000000);
        check({tag, "_dp"}, bus.dp, 1'b1);
    endtask

    task automatic scan_next(input string tag, input logic [3:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_dp, input bit inject);
        int blanks;
        blanks = 0;
        bus.tick_scan = 1'b1;
        @(negedge clk);
        bus.tick_scan = 1'b0;
        while (bus.an == 4'b1111 && blanks < 12) begin
            bus.tick_scan = (inject && blanks == 1);
            blanks++;
            @(negedge clk);
        end
        bus.tick_scan = 1'b0;
        check({tag, "_blank_len"}, blanks, 4);
        check({tag, "_an"}, bus.an, exp_an);
        check({tag, "_seg"}, bus.seg, exp_seg);
        check({tag, "_dp"}, bus.dp, exp_dp);
        repeat (15) @(negedge clk);
        check({tag, "_an_hold"}, bus.an, exp_an);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.tick_scan  = 1'b0;
        bus.tick_count = 1'b0;
        bus.run        = 1'b0;
        bus.clear      = 1'b0;
        #12;
        check("rst_an", bus.an, 4'b1111);
        check("rst_seg", bus.seg, 7'b1111111);
        check("rst_dp", bus.dp, 1'b1);
        check("rst_count", bus.count_bcd, 16'h0000);
        check("rst_wrap", bus.wrap, 1'b0);

        release_and_first_show("first");

        bus.run = 1'b1;
        count_pulse();
        check("inc_latency", bus.count_bcd, 16'h0001);
        repeat (6) count_pulse();
        check("count_7", bus.count_bcd, 16'h0007);
        check("seg_latched", bus.seg, 7'b1000000);

        scan_next("d1", 4'b1101, LEAD_SEG, 1'b1, 1'b0);
        scan_next("d2", 4'b1011, LEAD_SEG, DP2_EXP, 1'b0);
        scan_next("d3", 4'b0111, LEAD_SEG, 1'b1, 1'b1);
        scan_next("d0", 4'b1110, 7'b1111000, 1'b1, 1'b0);

        repeat (3) count_pulse();
        check("count_10", bus.count_bcd, 16'h0010);

        bus.tick_count = 1'b1;
        repeat (32) begin
            @(negedge clk);
            if (bus.wrap) wrap_seen = 1'b1;
        end
        bus.tick_count = 1'b0;
        check("count_42", bus.count_bcd, 16'h0042);

        bus.run = 1'b0;
        count_pulse();
        check("run0_ignored", bus.count_bcd, 16'h0042);
        bus.run = 1'b1;
        @(negedge clk);
        check("no_deferred", bus.count_bcd, 16'h0042);

        bus.clear      = 1'b1;
        bus.tick_count = 1'b1;
        @(negedge clk);
        bus.clear      = 1'b0;
        bus.tick_count = 1'b0;
        check("clear_prio_count", bus.count_bcd, 16'h0000);
        check("clear_prio_wrap", bus.wrap, 1'b0);

        bus.tick_count = 1'b1;
        repeat (9999) begin
            @(negedge clk);
            if (bus.wrap) wrap_seen = 1'b1;
        end
        bus.tick_count = 1'b0;
        check("count_9999", bus.count_bcd, 16'h9999);
        check("no_early_wrap", wrap_seen, 1'b0);

        count_pulse();
        check("wrap_count", bus.count_bcd, 16'h0000);
        check("wrap_high", bus.wrap, 1'b1);
        @(negedge clk);
        check("wrap_one_cycle", bus.wrap, 1'b0);

        count_pulse();
        check("pre_rst_count", bus.count_bcd, 16'h0001);
        check("pre_rst_an", bus.an, 4'b1110);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", bus.an, 4'b1111);
        check("async_rst_seg", bus.seg, 7'b1111111);
        check("async_rst_dp", bus.dp, 1'b1);
        check("async_rst_count", bus.count_bcd, 16'h0000);
        check("async_rst_wrap", bus.wrap, 1'b0);

        release_and_first_show("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter BLANK_CYCLES, default 16: inter-digit blanking length in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter DP_DIGIT, default 2: digit index whose decimal point is lit; a value of 4 or more means no point is lit.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port tick_scan, input, 1 bit: one-cycle strobe (~1 kHz) requesting the next digit.
REQ-006 SHALL have port tick_count, input, 1 bit: one-cycle strobe (1 Hz) requesting a count increment.
REQ-007 SHALL have port run, input, 1 bit: count enable, level-sensitive.
REQ-008 SHALL have port clear, input, 1 bit: synchronous counter clear.
REQ-009 SHALL have port an, output, 4 bits: digit anodes, active-low; an[0] is the ones digit.
REQ-010 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-012 SHALL have port count_bcd, output, 16 bits: four BCD digits, [3:0] = ones.
REQ-013 SHALL have port wrap, output, 1 bit: one-cycle pulse when the count rolls over from 9999 to 0000.

Function
REQ-014 Counter SHALL update on the clk edge following the qualifying input (latency 1): clear=1 -> 0000; else tick_count=1 and run=1 -> +1 BCD with ripple carry.
REQ-015 clear SHALL have priority over tick_count in the same cycle: count becomes 0000 and wrap stays 0.
REQ-016 tick_count SHALL be ignored while run=0; no increment is deferred.
REQ-017 Increment from 9999 SHALL give 0000 and assert wrap for exactly one cycle; no count_bcd nibble SHALL ever exceed 9.
REQ-018 Scan FSM SHALL have states BLANK and SHOW, plus a 2-bit digit index idx.
REQ-019 In BLANK: an=1111 and seg=1111111; a down-counter loaded with BLANK_CYCLES decrements each cycle; at 0 the FSM SHALL go to SHOW with idx+1 (mod 4).
REQ-020 Entering SHOW SHALL latch nibble idx of count_bcd into a display register; count changes during SHOW SHALL NOT alter seg until the next SHOW.
REQ-021 In SHOW: an[idx]=0, all other anodes 1; seg = decode(latched nibble); dp=0 only when idx==DP_DIGIT.
REQ-022 In SHOW, tick_scan=1 SHALL cause a transition to BLANK on the next edge; tick_scan during BLANK SHALL be ignored.
REQ-023 an, seg and dp SHALL be registered outputs, with no combinational path from any input.
REQ-024 Decoder SHALL map 0-9 to standard patterns (0=1000000, 1=1111001, 8=0000000); unreachable codes 10-15 SHALL give all segments off.

Reset
REQ-025 With rst_n=0 the block SHALL immediately set: an=1111, seg=1111111, dp=1, count_bcd=0000, wrap=0, FSM=BLANK, idx=3, blank counter=BLANK_CYCLES.
REQ-026 The first SHOW after reset release SHALL display idx 0 (3+1 mod 4); reset asserted mid-SHOW or mid-BLANK SHALL abort to the reset state with no glitch beyond all-off.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL force seg=1111111 and dp=1 in SHOW for every digit above the most significant nonzero digit; digit 0 is always shown. The anode timing SHALL be unchanged.
REQ-028 With LEADING_ZERO_BLANK_EN undefined, all four digits SHALL always be shown, including leading zeros.

Verification
REQ-029 Scenario: reset, run=1, 10 tick_count pulses -> count_bcd=0x0010, wrap never asserted.
REQ-030 Scenario: preload count 9999 via ticks, one more tick_count -> count_bcd=0x0000 and wrap high for exactly 1 cycle.
REQ-031 Scenario: tick_count and clear in the same cycle at count 0x0042 -> 0x0000, wrap=0; tick_count with run=0 -> count unchanged.
REQ-032 Scenario: BLANK_CYCLES=4, tick_scan every 20 cycles -> an sequence 1110,1101,1011,0111 repeating, each preceded by exactly 4 cycles of 1111; a tick_scan during BLANK is ignored.
REQ-033 Scenario: count 0x0007 with LEADING_ZERO_BLANK_EN -> digits 3..1 seg=1111111, digit 0 seg=1111000; without the macro, digits 3..1 seg=1000000.
REQ-034 Scenario: rst_n pulsed low mid-SHOW -> outputs at reset values within the same cycle (asynchronous), and the first digit shown after release is idx 0.
